stream_compare_multi: RTL and testbench
=======================================

Name: stream_compare_multi

Overview:
- Second-generation AXI-Stream comparator for a pair of NLINKS×32-bit streams (reference vs. device-under-test).
- Buffers each input in a small FIFO, so the two streams may arrive with up to DEPTH words of skew.
- Compares word-aligned entries under a per-link enable mask and keeps per-link error counters.
- Captures the first mismatch and drives a trigger output in pulse or sticky mode. Sits between two capture paths and the ILA/readout logic.

Parameters:
- NLINKS, 4, number of 32-bit links per word; TDATA_WIDTH = 32*NLINKS.
- DEPTH, 16, entries per input FIFO; power of 2, range 2..256.
- WORD_CNT_WIDTH, 32, width of the compared-word counter.
- ERR_CNT_WIDTH, 16, width of each per-link error counter and of the total error counter.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  reset; synchronous, active-low.
- S_AXIS_0_TDATA  in  TDATA_WIDTH  stream 0 data.
- S_AXIS_0_TVALID  in  1  stream 0 valid.
- S_AXIS_0_TREADY  out  1  stream 0 ready.
- S_AXIS_1_TDATA  in  TDATA_WIDTH  stream 1 data.
- S_AXIS_1_TVALID  in  1  stream 1 valid.
- S_AXIS_1_TREADY  out  1  stream 1 ready.
- active_links  in  NLINKS  bit i=1 enables comparison of link i (bits [32i+31:32i]).
- mismatch_mode  in  1  0 = pulse per mismatching compare, 1 = sticky until clear.
- clear  in  1  one-cycle pulse; zeroes counters, capture registers and sticky flags.
- latch  in  1  one-cycle pulse; snapshots live counters into the *_latched outputs.
- mismatch  out  1  trigger output.
- skew_overflow  out  1  sticky; set when one FIFO is full while the other is empty.
- word_count_latched  out  WORD_CNT_WIDTH  snapshot of the compared-word count.
- err_total_latched  out  ERR_CNT_WIDTH  snapshot of the count of mismatching words.
- link_err_latched  out  NLINKS*ERR_CNT_WIDTH  snapshot of the per-link counters; link i at [i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH].
- first_err_valid  out  1  a first mismatch has been captured.
- first_err_word  out  WORD_CNT_WIDTH  live word_count value at the first mismatch, i.e. its 0-based index.
- first_err_links  out  NLINKS  per-link mismatch vector of the first mismatch.

Behaviour:
- Reset (aresetn=0 at a clk edge): both FIFOs emptied. All counters, latched outputs, capture registers, mismatch and skew_overflow go to 0. TREADY is 0 while aresetn=0.
- Input FIFOs:
  - S_AXIS_n_TREADY = (count_n < DEPTH), combinational from registered count.
  - Push on TVALID&TREADY. A pushed word is poppable the following cycle.
- Compare:
  - Occurs in any cycle where both FIFOs are non-empty; both heads are popped in the same cycle.
  - A pop frees a slot no earlier than the next cycle's TREADY.
  - link_miss[i] = active_links[i] & (head0 link i != head1 link i).
  - word_miss = |link_miss.
- Counters (registered, visible one cycle after the compare):
  - word_count increments on every compare.
  - err_total increments on each compare with word_miss=1.
  - link_err[i] increments on link_miss[i].
  - All counters saturate at all-ones and never wrap.
- First-error capture: on the first compare with word_miss=1 since reset or clear, set first_err_valid and load first_err_word (pre-increment word_count) and first_err_links. Later mismatches do not update these until clear.
- mismatch output:
  - Registered; asserted in the cycle after a mismatching compare.
  - mode 0: 1-cycle pulse per mismatching compare, so back-to-back mismatches hold it high.
  - mode 1: set and held until clear.
  - Changing the mode mid-run affects only subsequent cycles.
- Latency: words handshaken on both inputs in cycle T are compared in T+1; mismatch, counters and capture update at T+2.
- skew_overflow: set when count_0==DEPTH && count_1==0, or vice versa; sticky until clear. Comparison stalls naturally and no data is dropped.
- latch: the latched outputs take the live counter values as of the latch cycle (before any same-cycle increment). They are otherwise held.
- clear:
  - Live counters, capture, mismatch and skew_overflow go to 0 on the next edge.
  - A compare in the same cycle as clear is not counted.
  - If clear and latch coincide, the latched outputs receive the pre-clear values.
  - FIFOs are not flushed.
- active_links = 0: no mismatches are ever flagged; word_count still increments.

Test Plan:
- Identical streams, 100 words both inputs, NLINKS=4, active_links=4'hF, latch afterwards → word_count_latched=100, err_total_latched=0, mismatch never asserted, first_err_valid=0.
- Stream 1 delayed 10 cycles vs stream 0, DEPTH=16, identical data → no stall beyond the delay, skew_overflow=0, 0 errors. Delay 20 cycles → TREADY_0 drops at 16 buffered words, skew_overflow=1, data still compared with 0 errors.
- Word 5 corrupted on link 2 and word 9 on links 0 and 3, mode 0 → one-cycle mismatch pulses exactly 2 cycles after each handshake; first_err_word=5, first_err_links=4'b0100; link_err = {1,1,0,1} for links 3..0; err_total=2.
- Same data with mode 1 → mismatch rises after word 5 and stays 1; clear → mismatch=0, counters 0, first_err_valid=0.
- Mismatch confined to link 1 with active_links=4'b1101 → no errors counted. Then ERR_CNT_WIDTH=4 with 20 mismatching words → link_err saturates at 15, err_total=15.
- Reset asserted with 5 words buffered mid-stream → FIFOs empty, all outputs 0 next cycle, TREADY=0 during reset and 1 after release.

Source files
------------

// File: rtl/stream_compare_multi.sv
// Dual-stream AXI-Stream comparator: buffers a reference and a device stream in
// small FIFOs, compares aligned words per 32-bit link, keeps saturating error
// counters, captures the first mismatch and drives a pulse/sticky trigger.
module stream_compare_multi #(
  parameter int unsigned NLINKS         = 4,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned WORD_CNT_WIDTH = 32,
  parameter int unsigned ERR_CNT_WIDTH  = 16,
  localparam int unsigned TDATA_WIDTH   = 32 * NLINKS
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [TDATA_WIDTH-1:0]          S_AXIS_0_TDATA,
  input  logic                            S_AXIS_0_TVALID,
  output logic                            S_AXIS_0_TREADY,
  input  logic [TDATA_WIDTH-1:0]          S_AXIS_1_TDATA,
  input  logic                            S_AXIS_1_TVALID,
  output logic                            S_AXIS_1_TREADY,
  input  logic [NLINKS-1:0]               active_links,
  input  logic                            mismatch_mode,
  input  logic                            clear,
  input  logic                            latch,
  output logic                            mismatch,
  output logic                            skew_overflow,
  output logic [WORD_CNT_WIDTH-1:0]       word_count_latched,
  output logic [ERR_CNT_WIDTH-1:0]        err_total_latched,
  output logic [NLINKS*ERR_CNT_WIDTH-1:0] link_err_latched,
  output logic                            first_err_valid,
  output logic [WORD_CNT_WIDTH-1:0]       first_err_word,
  output logic [NLINKS-1:0]               first_err_links
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LW    = NLINKS * ERR_CNT_WIDTH;

  // FIFO storage and bookkeeping, index 0 = reference stream, 1 = device stream
  logic [TDATA_WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q [2];
  logic [PTR_W-1:0]       wr_ptr_d [2];
  logic [PTR_W-1:0]       rd_ptr_q [2];
  logic [PTR_W-1:0]       rd_ptr_d [2];
  logic [CNT_W-1:0]       count_q  [2];
  logic [CNT_W-1:0]       count_d  [2];
  logic [TDATA_WIDTH-1:0] tdata    [2];
  logic                   tvalid   [2];
  logic                   tready   [2];
  logic                   push     [2];
  logic [TDATA_WIDTH-1:0] head     [2];

  logic                   compare;
  logic                   cmp_en;
  logic [NLINKS-1:0]      link_miss;
  logic                   word_miss;

  logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ERR_CNT_WIDTH-1:0]  err_tot_q, err_tot_d;
  logic [ERR_CNT_WIDTH-1:0]  link_err_q [NLINKS];
  logic [ERR_CNT_WIDTH-1:0]  link_err_d [NLINKS];

  logic [WORD_CNT_WIDTH-1:0] word_lat_q, word_lat_d;
  logic [ERR_CNT_WIDTH-1:0]  err_lat_q, err_lat_d;
  logic [LW-1:0]             link_lat_q, link_lat_d;

  logic                      fe_valid_q, fe_valid_d;
  logic [WORD_CNT_WIDTH-1:0] fe_word_q, fe_word_d;
  logic [NLINKS-1:0]         fe_links_q, fe_links_d;
  logic                      mismatch_q, mismatch_d;
  logic                      skew_q, skew_d;

  assign tdata[0]  = S_AXIS_0_TDATA;
  assign tdata[1]  = S_AXIS_1_TDATA;
  assign tvalid[0] = S_AXIS_0_TVALID;
  assign tvalid[1] = S_AXIS_1_TVALID;

  // Ready comes straight from the registered fill level and is held low in reset
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      tready[n] = aresetn && (count_q[n] < CNT_W'(DEPTH));
      push[n]   = tvalid[n] && tready[n];
      head[n]   = mem_q[n][rd_ptr_q[n]];
    end
  end

  assign S_AXIS_0_TREADY = tready[0];
  assign S_AXIS_1_TREADY = tready[1];

  // Both heads are consumed together whenever both FIFOs hold data
  assign compare = (count_q[0] != '0) && (count_q[1] != '0);
  assign cmp_en  = compare && !clear;

  // Per-link comparison of the two FIFO heads under the enable mask
  always_comb begin
    link_miss = '0;
    for (int unsigned i = 0; i < NLINKS; i++) begin
      link_miss[i] = active_links[i] && (head[0][32*i +: 32] != head[1][32*i +: 32]);
    end
  end

  assign word_miss = |link_miss;

  // FIFO pointer and fill-level update
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      count_d[n]  = count_q[n] + CNT_W'(push[n]) - CNT_W'(compare);
      if (push[n]) begin
        wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(1);
      end
      if (compare) begin
        rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(1);
      end
    end
  end

  // Counters, snapshots, first-error capture and trigger next-state
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_tot_d  = err_tot_q;
    word_lat_d = word_lat_q;
    err_lat_d  = err_lat_q;
    link_lat_d = link_lat_q;
    fe_valid_d = fe_valid_q;
    fe_word_d  = fe_word_q;
    fe_links_d = fe_links_q;
    mismatch_d = (cmp_en && word_miss) || (mismatch_mode && mismatch_q);
    skew_d     = skew_q
              || ((count_q[0] == CNT_W'(DEPTH)) && (count_q[1] == '0))
              || ((count_q[1] == CNT_W'(DEPTH)) && (count_q[0] == '0));
    for (int unsigned i = 0; i < NLINKS; i++) begin
      link_err_d[i] = link_err_q[i];
    end

    if (latch) begin
      word_lat_d = word_cnt_q;
      err_lat_d  = err_tot_q;
      for (int unsigned i = 0; i < NLINKS; i++) begin
        link_lat_d[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = link_err_q[i];
      end
    end

    if (cmp_en) begin
      if (word_cnt_q != '1) begin
        word_cnt_d = word_cnt_q + WORD_CNT_WIDTH'(1);
      end
      if (word_miss && (err_tot_q != '1)) begin
        err_tot_d = err_tot_q + ERR_CNT_WIDTH'(1);
      end
      for (int unsigned i = 0; i < NLINKS; i++) begin
        if (link_miss[i] && (link_err_q[i] != '1)) begin
          link_err_d[i] = link_err_q[i] + ERR_CNT_WIDTH'(1);
        end
      end
      if (word_miss && !fe_valid_q) begin
        fe_valid_d = 1'b1;
        fe_word_d  = word_cnt_q;
        fe_links_d = link_miss;
      end
    end

    if (clear) begin
      word_cnt_d = '0;
      err_tot_d  = '0;
      fe_valid_d = 1'b0;
      fe_word_d  = '0;
      fe_links_d = '0;
      mismatch_d = 1'b0;
      skew_d     = 1'b0;
      for (int unsigned i = 0; i < NLINKS; i++) begin
        link_err_d[i] = '0;
      end
    end
  end

  // FIFO data storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n]] <= tdata[n];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        count_q[n]  <= '0;
      end
      for (int unsigned i = 0; i < NLINKS; i++) begin
        link_err_q[i] <= '0;
      end
      word_cnt_q <= '0;
      err_tot_q  <= '0;
      word_lat_q <= '0;
      err_lat_q  <= '0;
      link_lat_q <= '0;
      fe_valid_q <= 1'b0;
      fe_word_q  <= '0;
      fe_links_q <= '0;
      mismatch_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        count_q[n]  <= count_d[n];
      end
      for (int unsigned i = 0; i < NLINKS; i++) begin
        link_err_q[i] <= link_err_d[i];
      end
      word_cnt_q <= word_cnt_d;
      err_tot_q  <= err_tot_d;
      word_lat_q <= word_lat_d;
      err_lat_q  <= err_lat_d;
      link_lat_q <= link_lat_d;
      fe_valid_q <= fe_valid_d;
      fe_word_q  <= fe_word_d;
      fe_links_q <= fe_links_d;
      mismatch_q <= mismatch_d;
      skew_q     <= skew_d;
    end
  end

  assign mismatch           = mismatch_q;
  assign skew_overflow      = skew_q;
  assign word_count_latched = word_lat_q;
  assign err_total_latched  = err_lat_q;
  assign link_err_latched   = link_lat_q;
  assign first_err_valid    = fe_valid_q;
  assign first_err_word     = fe_word_q;
  assign first_err_links    = fe_links_q;

endmodule

// File: tb/tb_stream_compare_multi.sv
// Directed bench for stream_compare_multi (4 links, depth 16, 4-bit error counters).
module tb_stream_compare_multi;

  localparam int unsigned NL = 4;
  localparam int unsigned EW = 4;
  localparam int unsigned WW = 32;
  localparam int unsigned TW = 32 * NL;

  logic           clk = 1'b0;
  logic           aresetn;
  logic [TW-1:0]  s0_data, s1_data;
  logic           s0_valid, s1_valid, s0_ready, s1_ready;
  logic [NL-1:0]  active_links;
  logic           mismatch_mode, clear, latch;
  logic           mismatch, skew_overflow;
  logic [WW-1:0]  wc_lat;
  logic [EW-1:0]  err_lat;
  logic [NL*EW-1:0] link_lat;
  logic           fev;
  logic [WW-1:0]  few;
  logic [NL-1:0]  fel;

  logic [TW-1:0]  d0 [128];
  logic [TW-1:0]  d1 [128];
  int             vectors = 0;
  int             miscompares = 0;
  int             low_at;

  always #5 clk = ~clk;

  stream_compare_multi #(
    .NLINKS(NL), .DEPTH(16), .WORD_CNT_WIDTH(WW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .S_AXIS_0_TDATA(s0_data), .S_AXIS_0_TVALID(s0_valid), .S_AXIS_0_TREADY(s0_ready),
    .S_AXIS_1_TDATA(s1_data), .S_AXIS_1_TVALID(s1_valid), .S_AXIS_1_TREADY(s1_ready),
    .active_links(active_links), .mismatch_mode(mismatch_mode),
    .clear(clear), .latch(latch),
    .mismatch(mismatch), .skew_overflow(skew_overflow),
    .word_count_latched(wc_lat), .err_total_latched(err_lat), .link_err_latched(link_lat),
    .first_err_valid(fev), .first_err_word(few), .first_err_links(fel)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_latch();
    latch = 1'b1;
    step();
    latch = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic logic [NL-1:0] miss_of(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic [NL-1:0] act);
    logic [NL-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NL); i++) begin
      m[i] = act[i] && (a[32*i +: 32] != b[32*i +: 32]);
    end
    return m;
  endfunction

  // Streams n words on each input, stream 1 starting dly cycles late; with chk_mm
  // (lockstep only) the trigger is checked every cycle against the expected value.
  task automatic run(input int n, input int dly, input bit chk_mm);
    int i0, i1, c, drain;
    bit prev_miss, cur_miss, sticky, hs0, hs1;
    i0 = 0; i1 = 0; c = 0; drain = 0;
    prev_miss = 1'b0; sticky = 1'b0;
    low_at = -1;
    while (drain < 3) begin
      if (c >= 2000) begin
        chk("run_timeout_words", 64'(i1), 64'(n));
        break;
      end
      s0_valid = (i0 < n);
      s0_data  = d0[i0];
      s1_valid = (c >= dly) && (i1 < n);
      s1_data  = d1[i1];
      hs0 = s0_valid && s0_ready;
      hs1 = s1_valid && s1_ready;
      if (s0_valid && !s0_ready && low_at < 0) low_at = i0;
      cur_miss = hs1 && (miss_of(d0[i1], d1[i1], active_links) != '0);
      step();
      if (hs0) i0++;
      if (hs1) i1++;
      if (chk_mm) begin
        sticky = sticky | prev_miss;
        chk("mismatch_cycle", 64'(mismatch), 64'(mismatch_mode ? sticky : prev_miss));
      end
      prev_miss = cur_miss;
      c++;
      if (i0 >= n && i1 >= n) drain++;
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; s0_data = '0; s1_data = '0; s0_valid = 1'b0; s1_valid = 1'b0;
    active_links = 4'hF; mismatch_mode = 1'b0; clear = 1'b0; latch = 1'b0;
    for (int i = 0; i < 128; i++) begin
      d0[i] = {$urandom, $urandom, $urandom, $urandom};
      d1[i] = d0[i];
    end

    // Reset state
    step(); step();
    chk("reset_tready0", 64'(s0_ready), 64'd0);
    chk("reset_tready1", 64'(s1_ready), 64'd0);
    chk("reset_mismatch", 64'(mismatch), 64'd0);
    chk("reset_wc_lat", 64'(wc_lat), 64'd0);
    chk("reset_fev", 64'(fev), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("release_tready0", 64'(s0_ready), 64'd1);

    // Identical streams, 100 words
    run(100, 0, 1'b1);
    do_latch();
    chk("ident_wc", 64'(wc_lat), 64'd100);
    chk("ident_err", 64'(err_lat), 64'd0);
    chk("ident_fev", 64'(fev), 64'd0);
    chk("ident_skew", 64'(skew_overflow), 64'd0);

    // Skew of 10 cycles fits in the FIFO
    do_clear();
    run(40, 10, 1'b0);
    do_latch();
    chk("skew10_no_stall", 64'(low_at), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("skew10_overflow", 64'(skew_overflow), 64'd0);
    chk("skew10_wc", 64'(wc_lat), 64'd40);
    chk("skew10_err", 64'(err_lat), 64'd0);

    // Skew of 20 cycles overflows: stream 0 stalls at 16 buffered words
    do_clear();
    run(40, 20, 1'b0);
    do_latch();
    chk("skew20_stall_at", 64'(low_at), 64'd16);
    chk("skew20_overflow", 64'(skew_overflow), 64'd1);
    chk("skew20_wc", 64'(wc_lat), 64'd40);
    chk("skew20_err", 64'(err_lat), 64'd0);

    // Corruption: word 5 link 2, word 9 links 0 and 3, pulse mode
    for (int i = 0; i < 128; i++) d1[i] = d0[i];
    d1[5] = d0[5] ^ (128'h1 << 64);
    d1[9] = d0[9] ^ ((128'h1 << 96) | 128'h1);
    do_clear();
    mismatch_mode = 1'b0;
    run(12, 0, 1'b1);
    do_latch();
    chk("pulse_fev", 64'(fev), 64'd1);
    chk("pulse_few", 64'(few), 64'd5);
    chk("pulse_fel", 64'(fel), 64'h4);
    chk("pulse_link_err", 64'(link_lat), 64'h1101);
    chk("pulse_err_total", 64'(err_lat), 64'd2);
    chk("pulse_wc", 64'(wc_lat), 64'd12);

    // Same data, sticky mode; then clear together with latch
    do_clear();
    mismatch_mode = 1'b1;
    run(12, 0, 1'b1);
    chk("sticky_held", 64'(mismatch), 64'd1);
    clear = 1'b1; latch = 1'b1;
    step();
    clear = 1'b0; latch = 1'b0;
    chk("clrlat_wc", 64'(wc_lat), 64'd12);
    chk("clrlat_err", 64'(err_lat), 64'd2);
    chk("clrlat_link", 64'(link_lat), 64'h1101);
    chk("clear_mismatch", 64'(mismatch), 64'd0);
    chk("clear_fev", 64'(fev), 64'd0);
    chk("clear_few", 64'(few), 64'd0);
    do_latch();
    chk("clear_wc", 64'(wc_lat), 64'd0);
    chk("clear_err", 64'(err_lat), 64'd0);
    chk("clear_link", 64'(link_lat), 64'h0);

    // Mismatch only on a masked-off link
    for (int i = 0; i < 128; i++) d1[i] = d0[i] ^ (128'h5 << 32);
    mismatch_mode = 1'b0;
    active_links = 4'b1101;
    run(10, 0, 1'b1);
    do_latch();
    chk("mask_err", 64'(err_lat), 64'd0);
    chk("mask_link", 64'(link_lat), 64'h0);
    chk("mask_wc", 64'(wc_lat), 64'd10);
    chk("mask_fev", 64'(fev), 64'd0);

    // 20 words wrong on every link: 4-bit counters saturate at 15
    for (int i = 0; i < 128; i++) d1[i] = ~d0[i];
    do_clear();
    active_links = 4'hF;
    mismatch_mode = 1'b1;
    run(20, 0, 1'b1);
    do_latch();
    chk("sat_link", 64'(link_lat), 64'hFFFF);
    chk("sat_err", 64'(err_lat), 64'hF);
    chk("sat_wc", 64'(wc_lat), 64'd20);
    chk("sat_few", 64'(few), 64'd0);
    chk("sat_fel", 64'(fel), 64'hF);

    // Reset with 5 words buffered on stream 0
    for (int i = 0; i < 5; i++) begin
      s0_valid = 1'b1;
      s0_data  = d0[i];
      step();
    end
    s0_valid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_tready0_low", 64'(s0_ready), 64'd0);
    chk("rst_tready1_low", 64'(s1_ready), 64'd0);
    step();
    chk("rst_mismatch", 64'(mismatch), 64'd0);
    chk("rst_skew", 64'(skew_overflow), 64'd0);
    chk("rst_wc_lat", 64'(wc_lat), 64'd0);
    chk("rst_err_lat", 64'(err_lat), 64'd0);
    chk("rst_link_lat", 64'(link_lat), 64'h0);
    chk("rst_fev", 64'(fev), 64'd0);
    chk("rst_fel", 64'(fel), 64'h0);
    aresetn = 1'b1;
    #1;
    chk("rel_tready0", 64'(s0_ready), 64'd1);
    chk("rel_tready1", 64'(s1_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      s1_valid = 1'b1;
      s1_data  = d1[i];
      step();
    end
    s1_valid = 1'b0;
    step(); step();
    do_latch();
    chk("rst_fifo_flushed_wc", 64'(wc_lat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
